// File: rtl/serial_to_parallel_32bit.sv
// serial_to_parallel_32bit
// Assembles a framed 1-bit serial stream into WIDTH-bit words. A frame starts
// on a bit qualified by frame_start; bits may arrive with arbitrary gaps.
// Each completed word goes into a single holding buffer (par_out/par_valid)
// drained by a valid/ready handshake. Sticky flags record words dropped
// because the buffer was still full (overrun) and partial frames that were
// restarted by a new frame_start (frame_abort).

module serial_to_parallel_32bit #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ser_in,
  input  logic                         ser_valid,
  input  logic                         frame_start,
  input  logic                         par_ready,
  input  logic                         clr_flags,
  output logic [WIDTH-1:0]             par_out,
  output logic                         par_valid,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         overrun,
  output logic                         frame_abort
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;

  // Insert one bit into the assembly register in the configured bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b);
    if (MSB_FIRST)
      return {cur[WIDTH-2:0], b};
    else
      return {b, cur[WIDTH-1:1]};
  endfunction

  logic             restart;
  logic             accept;
  logic             abort_evt;
  logic             complete;
  logic             deliver;
  logic             overrun_evt;
  logic [WIDTH-1:0] sr_next;

  // Decode the current input bit against the frame state.
  always_comb begin
    restart     = ser_valid && frame_start;
    accept      = ser_valid && (frame_start || (state == SHIFT));
    abort_evt   = restart && (state == SHIFT);
    // A frame_start on the last bit position restarts rather than completes.
    complete    = accept && !frame_start && (bit_count == CW'(WIDTH - 1));
    // A restart throws away whatever partial word was being assembled.
    sr_next     = restart ? shift_in('0, ser_in) : shift_in(sr, ser_in);
    deliver     = complete && (!par_valid || par_ready);
    overrun_evt = complete && par_valid && !par_ready;
  end

  // Frame assembly FSM: tracks IDLE/SHIFT, the shift register and the bit count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sr        <= '0;
      busy      <= 1'b0;
      bit_count <= '0;
    end else if (accept) begin
      sr <= sr_next;
      if (restart) begin
        state     <= SHIFT;
        busy      <= 1'b1;
        bit_count <= CW'(1);
      end else if (complete) begin
        state     <= IDLE;
        busy      <= 1'b0;
        bit_count <= '0;
      end else begin
        bit_count <= bit_count + CW'(1);
      end
    end
  end

  // Output holding buffer: load on completion when free or draining, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_out   <= '0;
      par_valid <= 1'b0;
    end else if (deliver) begin
      par_out   <= sr_next;
      par_valid <= 1'b1;
    end else if (par_valid && par_ready) begin
      par_valid <= 1'b0;
    end
  end

  // Sticky status flags; a set event in the same cycle beats clr_flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      overrun     <= overrun_evt | (overrun & ~clr_flags);
      frame_abort <= abort_evt | (frame_abort & ~clr_flags);
    end
  end

endmodule
